// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the binary_mul family of multipliers.
package binary_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/binary_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per enabled cycle, W cycles per product.
// Signed mode multiplies magnitudes and negates the result when the operand signs differ.
module binary_mul_seq
    import binary_mul_pkg::*;
#(
    parameter int unsigned W      = 13,
    parameter bit          SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    localparam int unsigned CW = cnt_width(W);

    mul_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           neg_q, neg_d;
    logic [2*W-1:0] p_q, p_d;

    logic [W:0]     addend;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return (SIGNED && x[W-1]) ? -x : x;
    endfunction

    // lo holds the remaining multiplier bits and fills with product bits as it shifts right.
    assign addend = lo_q[0] ? {1'b0, mcand_q} : '0;
    assign sum    = {1'b0, hi_q} + addend;
    assign prod   = {sum[W:1], sum[0], lo_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        p_d     = p_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_d = mag(a);
                        lo_d    = mag(b);
                        hi_d    = '0;
                        cnt_d   = '0;
                        neg_d   = SIGNED ? (a[W-1] ^ b[W-1]) : 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    hi_d  = prod[2*W-1:W];
                    lo_d  = prod[W-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        p_d     = neg_q ? -prod : prod;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule
